// File: rtl/ushift_reg.sv
// Universal shift register: hold, shift, rotate, load and clear, applied directly
// or repeated as a counted burst with busy/done handshake.
module ushift_reg #(
   parameter int WIDTH = 8,
   parameter int AW    = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       mode,
   input  logic             s_in_r,
   input  logic             s_in_l,
   input  logic [WIDTH-1:0] par_in,
   input  logic             start,
   input  logic [AW-1:0]    amt,
   output logic [WIDTH-1:0] q,
   output logic             s_out_r,
   output logic             s_out_l,
   output logic             busy,
   output logic             done
);

   typedef enum logic [2:0] {
      M_HOLD = 3'b000,
      M_SHR  = 3'b001,
      M_SHL  = 3'b010,
      M_LOAD = 3'b011,
      M_ROR  = 3'b100,
      M_ROL  = 3'b101,
      M_CLR  = 3'b110,
      M_RSVD = 3'b111
   } op_e;

   typedef enum logic {IDLE, RUN} state_e;

   state_e           state, state_nx;
   op_e              op_lat, op_lat_nx;
   logic [AW-1:0]    cnt, cnt_nx;
   logic [WIDTH-1:0] q_nx;
   logic             done_nx;
   op_e              mode_op;
   logic             burst_mode;

   function automatic logic [WIDTH-1:0] apply_op(
      input op_e              op,
      input logic [WIDTH-1:0] cur,
      input logic             sr,
      input logic             sl,
      input logic [WIDTH-1:0] pin
   );
      case (op)
         M_SHR:   apply_op = {sr, cur[WIDTH-1:1]};
         M_SHL:   apply_op = {cur[WIDTH-2:0], sl};
         M_LOAD:  apply_op = pin;
         M_ROR:   apply_op = {cur[0], cur[WIDTH-1:1]};
         M_ROL:   apply_op = {cur[WIDTH-2:0], cur[WIDTH-1]};
         M_CLR:   apply_op = '0;
         default: apply_op = cur;
      endcase
   endfunction

   assign mode_op    = op_e'(mode);
   assign burst_mode = mode_op inside {M_SHR, M_SHL, M_ROR, M_ROL};

   always_comb begin
      // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
      state_nx  = state;
      op_lat_nx = op_lat;
      cnt_nx    = cnt;
      q_nx      = q;
      done_nx   = 1'b0;
      case (state)
         IDLE: begin
            if (start && burst_mode) begin
               if (amt == '0) begin
                  done_nx = 1'b1;
               end else begin
                  op_lat_nx = mode_op;
                  cnt_nx    = amt;
                  state_nx  = RUN;
               end
            end else begin
               q_nx = apply_op(mode_op, q, s_in_r, s_in_l, par_in);
            end
         end
         RUN: begin
            q_nx   = apply_op(op_lat, q, s_in_r, s_in_l, par_in);
            cnt_nx = cnt - 1'b1;
            if (cnt == AW'(1)) begin
               state_nx = IDLE;
               done_nx  = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      if (!rst) begin
         state  <= IDLE;
         op_lat <= M_HOLD;
         cnt    <= '0;
         q      <= '0;
         done   <= 1'b0;
      end else begin
         state  <= state_nx;
         op_lat <= op_lat_nx;
         cnt    <= cnt_nx;
         q      <= q_nx;
         done   <= done_nx;
      end
   end

   assign busy    = (state == RUN);
   assign s_out_r = q[0];
   assign s_out_l = q[WIDTH-1];

endmodule

// File: tb/tb_ushift_reg.sv
// Self-checking bench for ushift_reg: direct-mode vector table plus burst,
// abort and reset sequences, with expected q values routed through a scoreboard queue.
module tb_ushift_reg;

   localparam int WIDTH = 8;
   localparam int AW    = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic [2:0]       mode;
   logic             s_in_r, s_in_l, start;
   logic [WIDTH-1:0] par_in;
   logic [AW-1:0]    amt;
   logic [WIDTH-1:0] q;
   logic             s_out_r, s_out_l, busy, done;

   int n_tests = 0;
   int n_fail  = 0;
   logic [WIDTH-1:0] sb_q[$];
   logic [WIDTH-1:0] model_q;

   typedef struct {
      logic [2:0]       mode;
      logic             sr;
      logic             sl;
      logic             start;
      logic [WIDTH-1:0] par;
      logic [WIDTH-1:0] exp_q;
   } vec_t;

   vec_t vecs[16];

   ushift_reg #(.WIDTH(WIDTH), .AW(AW)) dut (
      .clk(clk), .rst(rst), .mode(mode), .s_in_r(s_in_r), .s_in_l(s_in_l),
      .par_in(par_in), .start(start), .amt(amt), .q(q), .s_out_r(s_out_r),
      .s_out_l(s_out_l), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive_idle();
      mode = 3'b000; start = 1'b0; s_in_r = 1'b0; s_in_l = 1'b0; par_in = '0; amt = '0;
   endtask

   // Launches a burst, optionally pokes start/load during it, then checks
   // busy length, final q, and a single done pulse.
   task automatic burst(input string name, input logic [2:0] m, input logic [AW-1:0] a,
                        input logic sr, input logic sl, input logic [WIDTH-1:0] exp_final,
                        input logic poke);
      int busy_cycles = 0;
      int guard = 0;
      logic [WIDTH-1:0] exp_pop;
      mode = m; start = 1'b1; amt = a; s_in_r = sr; s_in_l = sl;
      sb_q.push_back(exp_final);
      tick();
      check({name, "_start_q"}, q, model_q);
      check({name, "_start_busy"}, busy, (a != 0));
      check({name, "_start_done"}, done, (a == 0));
      if (busy) busy_cycles++;
      start = poke; mode = poke ? 3'b011 : 3'b000; par_in = 8'h00;
      while (busy && guard < 40) begin
         tick();
         guard++;
         if (busy) busy_cycles++;
         if (busy && done) check({name, "_busy_and_done"}, 1, 0);
      end
      drive_idle();
      check({name, "_busy_cycles"}, busy_cycles, a);
      check({name, "_done_pulse"}, done, 1);
      exp_pop = sb_q.pop_front();
      check({name, "_final_q"}, q, exp_pop);
      model_q = exp_pop;
      tick();
      check({name, "_done_clear"}, done, 0);
      check({name, "_hold_q"}, q, model_q);
   endtask

   task automatic load(input logic [WIDTH-1:0] v);
      mode = 3'b011; par_in = v; start = 1'b0;
      tick();
      drive_idle();
      check("load_q", q, v);
      model_q = v;
   endtask

   initial begin
      logic [WIDTH-1:0] exp_pop;
      vecs[0]  = '{3'b011, 1'b0, 1'b0, 1'b0, 8'hA5, 8'hA5};
      vecs[1]  = '{3'b001, 1'b1, 1'b0, 1'b0, 8'h00, 8'hD2};
      vecs[2]  = '{3'b010, 1'b0, 1'b1, 1'b0, 8'h00, 8'hA5};
      vecs[3]  = '{3'b100, 1'b0, 1'b0, 1'b0, 8'h00, 8'hD2};
      vecs[4]  = '{3'b101, 1'b0, 1'b0, 1'b0, 8'h00, 8'hA5};
      vecs[5]  = '{3'b010, 1'b0, 1'b0, 1'b0, 8'h00, 8'h4A};
      vecs[6]  = '{3'b001, 1'b0, 1'b0, 1'b0, 8'h00, 8'h25};
      vecs[7]  = '{3'b011, 1'b0, 1'b0, 1'b0, 8'h3C, 8'h3C};
      vecs[8]  = '{3'b000, 1'b1, 1'b1, 1'b0, 8'hFF, 8'h3C};
      vecs[9]  = '{3'b000, 1'b0, 1'b1, 1'b0, 8'h00, 8'h3C};
      vecs[10] = '{3'b000, 1'b1, 1'b0, 1'b0, 8'h00, 8'h3C};
      vecs[11] = '{3'b111, 1'b1, 1'b1, 1'b0, 8'hFF, 8'h3C};
      vecs[12] = '{3'b111, 1'b0, 1'b0, 1'b0, 8'h00, 8'h3C};
      vecs[13] = '{3'b111, 1'b1, 1'b0, 1'b0, 8'h11, 8'h3C};
      vecs[14] = '{3'b110, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
      vecs[15] = '{3'b011, 1'b0, 1'b0, 1'b1, 8'h81, 8'h81};

      rst = 1'b0;
      drive_idle();
      #12;
      @(negedge clk);
      check("reset_q", q, 0);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      rst = 1'b1;
      model_q = '0;

      for (int i = 0; i < 16; i++) begin
         mode = vecs[i].mode; s_in_r = vecs[i].sr; s_in_l = vecs[i].sl;
         start = vecs[i].start; par_in = vecs[i].par; amt = 4'd5;
         sb_q.push_back(vecs[i].exp_q);
         tick();
         exp_pop = sb_q.pop_front();
         check($sformatf("vec%0d_q", i), q, exp_pop);
         check($sformatf("vec%0d_s_out_r", i), s_out_r, exp_pop[0]);
         check($sformatf("vec%0d_s_out_l", i), s_out_l, exp_pop[WIDTH-1]);
         check($sformatf("vec%0d_busy", i), busy, 0);
         model_q = exp_pop;
      end
      drive_idle();

      burst("rol3", 3'b101, 4'd3, 1'b0, 1'b0, 8'h0C, 1'b0);

      load(8'hFF);
      burst("shr9", 3'b001, 4'd9, 1'b0, 1'b0, 8'h00, 1'b0);

      load(8'h96);
      burst("shl4_poked", 3'b010, 4'd4, 1'b0, 1'b1, 8'h6F, 1'b1);
      burst("amt0", 3'b001, 4'd0, 1'b1, 1'b0, 8'h6F, 1'b0);

      load(8'hAA);
      burst("ror11", 3'b100, 4'd11, 1'b0, 1'b0, 8'h55, 1'b0);

      load(8'h5A);
      mode = 3'b001; start = 1'b1; amt = 4'd5; s_in_r = 1'b1;
      tick();
      start = 1'b0; mode = 3'b000;
      tick();
      tick();
      check("abort_mid_q", q, 8'hD6);
      check("abort_mid_busy", busy, 1);
      rst = 1'b0;
      #1;
      check("abort_q", q, 0);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      tick();
      tick();
      check("abort_no_done", done, 0);
      rst = 1'b1;
      mode = 3'b011; par_in = 8'h77;
      tick();
      drive_idle();
      check("post_reset_load", q, 8'h77);
      check("post_reset_busy", busy, 0);
      check("post_reset_done", done, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ushift_reg.md
USHIFT_REG -- requirements
Module: ushift_reg

Interface
REQ-001 Parameter WIDTH, default 8: register width in bits, minimum 2.
REQ-002 Parameter AW, default 4: width of the burst shift-amount input.
REQ-003 clk  input  1: rising-edge clock.
REQ-004 rst  input  1: reset, asynchronous, active-low.
REQ-005 mode  input  3: operation select; see REQ-015.
REQ-006 s_in_r  input  1: serial input for right shift; enters q[WIDTH-1].
REQ-007 s_in_l  input  1: serial input for left shift; enters q[0].
REQ-008 par_in  input  WIDTH: parallel load data.
REQ-009 start  input  1: burst request, sampled on the clock edge.
REQ-010 amt  input  AW: number of burst operations, unsigned.
REQ-011 q  output  WIDTH: register contents.
REQ-012 s_out_r  output  1: equals q[0], combinational from q.
REQ-013 s_out_l  output  1: equals q[WIDTH-1], combinational from q.
REQ-014 busy  output  1: high while a burst is running; done  output  1: one-cycle burst-complete pulse.

Function
REQ-015 Mode encoding:
- 000: hold.
- 001: shift right, q <= {s_in_r, q[WIDTH-1:1]}.
- 010: shift left, q <= {q[WIDTH-2:0], s_in_l}.
- 011: parallel load, q <= par_in.
- 100: rotate right.
- 101: rotate left.
- 110: synchronous clear to 0.
- 111: hold (reserved).
REQ-016 Two states: IDLE and RUN; reset enters IDLE.
REQ-017 IDLE with start=0: the mode operation executes on every rising edge (direct mode).
REQ-018 IDLE, start=1, mode in {001,010,100,101}, amt!=0: no q change on that edge. The block latches mode and loads the counter with amt. It enters RUN with busy=1.
REQ-019 RUN: each edge performs the latched operation and decrements the counter. Serial inputs are sampled live each edge.
REQ-020 The edge that performs the final operation (counter==1) sets the state to IDLE, busy=0 and done=1. done clears on the following edge.
REQ-021 A burst started at edge k performs its operations on edges k+1 through k+amt. busy is high for exactly amt cycles.
REQ-022 RUN ignores the mode and start inputs.
REQ-023 start=1 in IDLE with amt==0: q unchanged, the block stays IDLE, and done pulses for one cycle after that edge.
REQ-024 start=1 in IDLE with any other mode: start is ignored and the mode executes as in direct mode.
REQ-025 amt may exceed WIDTH: shifts continue the full amt count, and rotates wrap modulo WIDTH naturally.
REQ-026 done and busy are never high in the same cycle.

Reset
REQ-027 On rst low, asynchronously: q=0, busy=0, done=0, counter=0, state=IDLE.
REQ-028 Reset during RUN aborts the burst; no done pulse is generated.
REQ-029 After rst deasserts, the first rising edge operates normally.

Verification (WIDTH=8, AW=4)
REQ-030 Load 0xA5, then shift right one edge with s_in_r=1 -> q=0xD2. s_out_r is 1 before the shift and 0 after.
REQ-031 q=0x81, start with mode=101 and amt=3 -> busy high 3 cycles, q=0x0C, then done high exactly 1 cycle.
REQ-032 q=0xFF, burst with mode=001, amt=9 and s_in_r=0 -> busy high 9 cycles, final q=0x00, one done pulse.
REQ-033 Assert start again with mode=011 during a burst -> ignored, burst result unchanged. Then start with amt=0 -> q unchanged, single done pulse, busy stays 0.
REQ-034 Assert rst low mid-burst (after 2 of 5 ops) -> q=0, busy=0 immediately, no done. Direct mode 011 then works on the first edge after release.
REQ-035 Load 0x3C, apply mode 000 and 111 for 3 edges each -> q=0x3C. Then mode 110 -> q=0x00 on the next edge.
